// File: rtl/dispatch_queue.sv
// In-order dispatch FIFO: decoded instructions wait here and issue one at a time to the unit named in each entry.
// Optional DISPATCH_QUEUE_STATS_EN adds a saturating head-stall cycle counter (stall_cycles).
module dispatch_queue #(
  parameter int RS_ID_WIDTH   = 5,
  parameter int NUM_UNITS     = 8,
  parameter int PAYLOAD_WIDTH = 64,
  parameter int DEPTH         = 4,
  parameter int UNIT_W        = $clog2(NUM_UNITS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [PAYLOAD_WIDTH-1:0]         in_payload,
  input  logic [UNIT_W-1:0]                in_unit,
  output logic [NUM_UNITS-1:0]             out_valid,
  input  logic [NUM_UNITS-1:0]             out_ready,
  output logic [PAYLOAD_WIDTH-1:0]         out_payload,
  input  logic [NUM_UNITS*RS_ID_WIDTH-1:0] unit_id,
  output logic [RS_ID_WIDTH-1:0]           id_taken,
  output logic                             id_taken_valid,
  output logic [UNIT_W-1:0]                id_taken_unit,
  output logic                             illegal,
`ifdef DISPATCH_QUEUE_STATS_EN
  output logic [31:0]                      stall_cycles,
`endif
  output logic [$clog2(DEPTH):0]           count
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int NSLOT = 1 << UNIT_W;

  logic [PAYLOAD_WIDTH-1:0] payload_mem [DEPTH];
  logic [UNIT_W-1:0]        unit_mem    [DEPTH];

  logic [PW-1:0]          wr_ptr_reg;
  logic [PW-1:0]          rd_ptr_reg;
  logic [CW-1:0]          count_reg;
  logic [CW-1:0]          count_next;
  logic                   illegal_reg;
  logic [NSLOT-1:0]       unit_legal;
  logic [RS_ID_WIDTH-1:0] id_slot [NSLOT];
  logic [UNIT_W-1:0]      head_unit;
  logic                   head_valid;
  logic                   accept;
  logic                   push;
  logic                   transfer;

  // Every encodable unit index gets a slot; indices past NUM_UNITS are marked illegal and offer no ID.
  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < NUM_UNITS) begin : g_live
        assign unit_legal[gi] = 1'b1;
        assign id_slot[gi]    = unit_id[gi*RS_ID_WIDTH +: RS_ID_WIDTH];
      end else begin : g_pad
        assign unit_legal[gi] = 1'b0;
        assign id_slot[gi]    = '0;
      end
    end
  endgenerate

  assign head_unit   = unit_mem[rd_ptr_reg];
  assign out_payload = payload_mem[rd_ptr_reg];
  assign head_valid  = !rst && (count_reg != '0);

  generate
    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_out_valid
      assign out_valid[gi] = head_valid && (head_unit == UNIT_W'(gi));
    end
  endgenerate

  // Full blocks input regardless of a same-cycle pop, keeping the ready path free of out_ready.
  assign in_ready = rst || (count_reg != CW'(DEPTH));
  assign accept   = in_valid && in_ready && !rst;
  assign push     = accept && unit_legal[in_unit];
  assign transfer = |(out_valid & out_ready);

  assign id_taken_valid = transfer;
  assign id_taken       = transfer ? id_slot[head_unit] : '0;
  assign id_taken_unit  = transfer ? head_unit : '0;
  assign illegal        = illegal_reg;
  assign count          = count_reg;

  assign count_next = count_reg + CW'(push) - CW'(transfer);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      illegal_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (transfer) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
      if (accept && !unit_legal[in_unit]) begin
        illegal_reg <= 1'b1;
      end
    end
  end

  // Entry storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      payload_mem[wr_ptr_reg] <= in_payload;
      unit_mem[wr_ptr_reg]    <= in_unit;
    end
  end

`ifdef DISPATCH_QUEUE_STATS_EN
  logic [31:0] stall_cycles_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_reg <= '0;
    end else if (head_valid && !transfer && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
`endif

endmodule
